// File: rtl/ux607_tl8_qspi_rdbridge.sv
// ---------------------------------------------------------------------------
// ux607_tl8_qspi_rdbridge
//
// Terminating TileLink slave on the 8-bit QSPI side of the 32->8 width
// converter. Each Get becomes one read command to the QSPI flash controller.
// The returned bytes stream straight back as AccessAckData beats. Puts and
// unsupported opcodes have all of their A beats drained, then get one
// AccessAck with error set, because the flash window is read-only.
//
// Ports
//   clock, reset            core clock, asynchronous active-high reset
//   a_*_i / a_ready_o       narrow TileLink A channel (one request in flight)
//   d_*_o / d_ready_i       narrow TileLink D channel
//   cmd_*_o / cmd_ready_i   read command to flash controller (addr, length)
//   rx_*_i / rx_ready_o     byte stream returned by the flash controller
//
// Build option
//   UX607_QSPI_RDBRIDGE_TIMEOUT_EN
//     When this macro is defined, a DATA-state idle counter is added. After 255
//     cycles without a returned byte, the rest of the burst is answered with
//     error beats of data 0. Without the macro, DATA waits forever.
// ---------------------------------------------------------------------------
module ux607_tl8_qspi_rdbridge (
  input  logic        clock,
  input  logic        reset,
  output logic        a_ready_o,
  input  logic        a_valid_i,
  input  logic [2:0]  a_opcode_i,
  input  logic [2:0]  a_size_i,
  input  logic [1:0]  a_source_i,
  input  logic [29:0] a_address_i,
  input  logic        a_mask_i,
  input  logic [7:0]  a_data_i,
  input  logic        d_ready_i,
  output logic        d_valid_o,
  output logic [2:0]  d_opcode_o,
  output logic [1:0]  d_param_o,
  output logic [2:0]  d_size_o,
  output logic [1:0]  d_source_o,
  output logic        d_sink_o,
  output logic        d_addr_lo_o,
  output logic [7:0]  d_data_o,
  output logic        d_error_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [29:0] cmd_addr_o,
  output logic [5:0]  cmd_len_o,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [7:0]  rx_data_i
);

  localparam logic [2:0] OP_GET            = 3'd4;
  localparam logic [2:0] MAX_SIZE          = 3'd5;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    WDRAIN = 3'd3,
    WACK   = 3'd4
  } state_e;

  // The flash window handles at most 32 bytes. Larger sizes are treated as 32.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > MAX_SIZE) ? MAX_SIZE : size;
  endfunction

  // The index of the last beat is (1 << size) - 1. It doubles as the low-address mask.
  function automatic logic [5:0] last_beat(input logic [2:0] size);
    return (6'd1 << clamp_size(size)) - 6'd1;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  source_q, source_d;
  logic [29:0] addr_q, addr_d;
  logic [5:0]  cnt_q, cnt_d;
  // This is the parity of the beats already returned. It drives d_addr_lo.
  logic        par_q, par_d;
  logic        timed_out;

  // Write data and mask are discarded by design.
  logic        unused_inputs;
  assign unused_inputs = ^{a_mask_i, a_data_i};

`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
  logic [7:0]  idle_q, idle_d;
  // The counter saturates at 255. From then on, the rest of the burst is error beats.
  assign timed_out = (idle_q == 8'hFF);
`else
  assign timed_out = 1'b0;
`endif

  // Constant and latched D-channel fields.
  assign d_param_o   = 2'd0;
  assign d_sink_o    = 1'b0;
  assign d_size_o    = size_q;
  assign d_source_o  = source_q;
  assign d_addr_lo_o = addr_q[0] ^ par_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      size_q   <= 3'd0;
      source_q <= 2'd0;
      addr_q   <= 30'd0;
      cnt_q    <= 6'd0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
    end
  end

`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    source_d    = source_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
    idle_d      = idle_q;
`endif
    a_ready_o   = 1'b0;
    d_valid_o   = 1'b0;
    d_opcode_o  = D_ACCESS_ACK;
    d_data_o    = 8'd0;
    d_error_o   = 1'b0;
    cmd_valid_o = 1'b0;
    cmd_addr_o  = 30'd0;
    cmd_len_o   = 6'd0;
    rx_ready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        a_ready_o = 1'b1;
        if (a_valid_i) begin
          size_d   = a_size_i;
          source_d = a_source_i;
          addr_d   = a_address_i;
          cnt_d    = last_beat(a_size_i);
          par_d    = 1'b0;
          if (a_opcode_i == OP_GET) begin
            state_d = CMD;
          end else if (last_beat(a_size_i) == 6'd0) begin
            state_d = WACK;
          end else begin
            state_d = WDRAIN;
          end
        end
      end

      CMD: begin
        cmd_valid_o = 1'b1;
        cmd_addr_o  = addr_q & ~{24'd0, last_beat(size_q)};
        cmd_len_o   = last_beat(size_q) + 6'd1;
        if (cmd_ready_i) begin
          state_d = DATA;
`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
          idle_d  = 8'd0;
`endif
        end
      end

      DATA: begin
        d_opcode_o = D_ACCESS_ACK_DATA;
        if (timed_out) begin
          // After a timeout, the missing bytes are answered locally and rx is never consumed.
          d_valid_o = 1'b1;
          d_error_o = 1'b1;
        end else begin
          d_valid_o  = rx_valid_i;
          d_data_o   = rx_data_i;
          rx_ready_o = d_ready_i;
        end
`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
        if (rx_valid_i && d_ready_i && !timed_out) begin
          idle_d = 8'd0;
        end else if (!timed_out) begin
          idle_d = idle_q + 8'd1;
        end
`endif
        if ((rx_valid_i || timed_out) && d_ready_i) begin
          par_d = ~par_q;
          if (cnt_q == 6'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      WDRAIN: begin
        // The first write beat was taken in IDLE. cnt counts the beats still expected.
        a_ready_o = 1'b1;
        if (a_valid_i) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = WACK;
          end
        end
      end

      WACK: begin
        d_valid_o  = 1'b1;
        d_opcode_o = D_ACCESS_ACK;
        d_error_o  = 1'b1;
        if (d_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ux607_tl8_qspi_rdbridge.sv
`timescale 1ns/1ps
module tb_ux607_tl8_qspi_rdbridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_ready, a_valid, a_mask;
  logic [2:0]  a_opcode, a_size;
  logic [1:0]  a_source;
  logic [29:0] a_address;
  logic [7:0]  a_data;
  logic        d_ready, d_valid, d_sink, d_addr_lo, d_error;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param, d_source;
  logic [7:0]  d_data;
  logic        cmd_valid, cmd_ready;
  logic [29:0] cmd_addr;
  logic [5:0]  cmd_len;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;

  always #5 clock = ~clock;

  ux607_tl8_qspi_rdbridge dut (
    .clock(clock), .reset(reset),
    .a_ready_o(a_ready), .a_valid_i(a_valid), .a_opcode_i(a_opcode), .a_size_i(a_size),
    .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask), .a_data_i(a_data),
    .d_ready_i(d_ready), .d_valid_o(d_valid), .d_opcode_o(d_opcode), .d_param_o(d_param),
    .d_size_o(d_size), .d_source_o(d_source), .d_sink_o(d_sink), .d_addr_lo_o(d_addr_lo),
    .d_data_o(d_data), .d_error_o(d_error),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired t=%0t", nm, $time);
  endtask

  // Flash contents as seen by the bench.
  function automatic logic [7:0] mem_byte(input logic [29:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5C;
  endfunction

  // Stimulus knobs, written by the main sequence only.
  int         dr_mode  = 2;   // 0 random, 1 toggle, 2 always ready
  int         cr_mode  = 0;   // 0 random, 1 held low, 2 always ready
  int         rx_limit = 32;  // bytes the flash returns per command
  int         ovr_n    = 0;   // leading bytes taken from ovr[] instead of mem_byte
  logic [7:0] ovr [32];

  // Behavioural model, written by the monitor only.
  bit          m_cmd_pend, m_data, m_ack;
  int          m_drain, m_len, m_idx, m_idle;
  logic [2:0]  m_size;
  logic [1:0]  m_src;
  logic [29:0] m_addr, m_cmd_addr;
  logic [7:0]  rxq [$];
  logic [7:0]  expq [$];
  int          rx_fire_cnt = 0;
  int          cmd_cnt = 0;
  logic [29:0] last_cmd_addr;
  logic [5:0]  last_cmd_len;
  logic [7:0]  log_data [$];
  logic [2:0]  log_op [$];
  logic        log_err [$];
  logic        log_lo [$];
  logic [1:0]  log_src [$];
  logic [2:0]  log_size [$];

  function automatic bit model_idle();
    return !m_cmd_pend && !m_data && !m_ack && (m_drain == 0);
  endfunction

  // Monitor and compare process. It samples on the falling edge, so the fires seen here are the ones that happen at the next rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_ctl", {a_ready, d_valid, cmd_valid, rx_ready}, 4'b1000);
        chk("rst_dfields", {d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error}, 0);
        chk("rst_cmd", {cmd_addr, cmd_len}, 0);
        m_cmd_pend = 0; m_data = 0; m_ack = 0; m_drain = 0; m_idx = 0; m_idle = 0;
        rxq.delete(); expq.delete();
      end else begin
        bit to, af, cf, df, rf, exp_dv;
        logic [7:0] exp_byte;
        to = 0;
`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
        to = m_data && (m_idle >= 255);
`endif
        chk("a_ready", a_ready, !(m_cmd_pend || m_data || m_ack));
        chk("cmd_valid", cmd_valid, m_cmd_pend);
        if (m_cmd_pend) chk("cmd_addr_len", {cmd_addr, cmd_len}, {m_cmd_addr, 6'(m_len)});
        exp_dv = m_ack ? 1'b1 : (m_data ? (to ? 1'b1 : rx_valid) : 1'b0);
        chk("d_valid", d_valid, exp_dv);
        chk("rx_ready", rx_ready, (m_data && !to) ? d_ready : 1'b0);

        af = a_valid && a_ready;
        cf = cmd_valid && cmd_ready;
        df = d_valid && d_ready;
        rf = rx_valid && rx_ready;

        if (rf) begin
          if (rxq.size() > 0) void'(rxq.pop_front());
          rx_fire_cnt++;
        end
`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
        if (m_data) begin
          if (rf) m_idle = 0;
          else if (m_idle < 255) m_idle++;
        end
`endif
        if (df) begin
          if (m_ack) begin
            chk("ack_beat", {d_opcode, d_data, d_error, d_size, d_source, d_addr_lo, d_param, d_sink},
                {3'd0, 8'd0, 1'b1, m_size, m_src, m_addr[0], 2'd0, 1'b0});
            m_ack = 0;
          end else if (m_data) begin
            exp_byte = (to || expq.size() == 0) ? 8'd0 : expq[0];
            chk("data_beat", {d_opcode, d_data, d_error, d_size, d_source, d_addr_lo, d_param, d_sink},
                {3'd1, exp_byte, to, m_size, m_src, m_addr[0] ^ m_idx[0], 2'd0, 1'b0});
            if (!to && expq.size() > 0) void'(expq.pop_front());
            m_idx++;
            if (m_idx == m_len) begin
              m_data = 0;
              rxq.delete(); expq.delete();
            end
          end
          log_data.push_back(d_data); log_op.push_back(d_opcode); log_err.push_back(d_error);
          log_lo.push_back(d_addr_lo); log_src.push_back(d_source); log_size.push_back(d_size);
        end
        if (cf) begin
          m_cmd_pend = 0; m_data = 1; m_idx = 0; m_idle = 0;
          cmd_cnt++; last_cmd_addr = cmd_addr; last_cmd_len = cmd_len;
          for (int k = 0; k < m_len && k < rx_limit; k++) begin
            logic [7:0] b;
            b = (k < ovr_n) ? ovr[k] : mem_byte(m_cmd_addr + 30'(k));
            rxq.push_back(b);
            expq.push_back(b);
          end
        end
        if (af) begin
          if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_ack = 1;
          end else begin
            int sc, n;
            sc = (a_size > 3'd5) ? 5 : int'(a_size);
            n = 1 << sc;
            m_size = a_size; m_src = a_source; m_addr = a_address;
            if (a_opcode == 3'd4) begin
              m_cmd_pend = 1;
              m_len = n;
              m_cmd_addr = 30'((int'(a_address) / n) * n);
            end else if (n == 1) begin
              m_ack = 1;
            end else begin
              m_drain = n - 1;
            end
          end
        end
      end
    end
  end

  // Responder side: d_ready, cmd_ready and the flash byte stream.
  initial begin
    int  rx_seen = 0;
    bit  rx_real = 0;
    d_ready = 0; cmd_ready = 0; rx_valid = 0; rx_data = 0;
    forever begin
      @(posedge clock);
      #1;
      case (dr_mode)
        0:       d_ready = 1'($urandom_range(0, 1));
        1:       d_ready = ~d_ready;
        default: d_ready = 1'b1;
      endcase
      case (cr_mode)
        0:       cmd_ready = ($urandom_range(0, 3) != 0);
        1:       cmd_ready = 1'b0;
        default: cmd_ready = 1'b1;
      endcase
      if (rx_valid && rx_real && rx_fire_cnt == rx_seen && rxq.size() > 0) begin
        rx_data = rxq[0];   // hold a real byte until it is taken
      end else begin
        rx_seen = rx_fire_cnt;
        if (rxq.size() > 0) begin
          rx_valid = ($urandom_range(0, 3) != 0);
          rx_data  = rxq[0];
          rx_real  = 1;
        end else if (!m_data) begin
          // Stray bytes outside a burst must never be consumed.
          rx_valid = ($urandom_range(0, 3) == 0);
          rx_data  = 8'($urandom);
          rx_real  = 0;
        end else begin
          rx_valid = 0;
          rx_real  = 0;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                      input logic [29:0] addr);
    int nb;
    nb = (op == 3'd4) ? 1 : (1 << ((sz > 3'd5) ? 5 : int'(sz)));
    for (int i = 0; i < nb; i++) begin
      bit fired;
      int t;
      a_valid = 1; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
      a_data = 8'($urandom); a_mask = 1'($urandom);
      fired = 0; t = 0;
      while (!fired && t < 3000) begin
        @(negedge clock);
        fired = a_ready;
        t++;
      end
      @(posedge clock);
      #1;
      a_valid = 0;
      if (!fired) fail_bound("a_accept");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input int limit, input string nm);
    bit done;
    done = 0;
    for (int t = 0; t < limit && !done; t++) begin
      @(posedge clock);
      #2;
      done = model_idle();
    end
    if (!done) fail_bound(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0; a_mask = 0; a_data = 0;
    reset = 1;
    #1;
    chk("rst0_ctl", {a_ready, d_valid, cmd_valid, rx_ready}, 4'b1000);
    repeat (3) @(posedge clock);
    #1;
    reset = 0;

    // Get of size 0 at an odd address, returning 0xA5.
    dr_mode = 2; cr_mode = 0; ovr[0] = 8'hA5; ovr_n = 1;
    b = log_data.size();
    send(3'd4, 3'd0, 2'd2, 30'h123);
    wait_idle(500, "t1_idle");
    chk("t1_cmd", {last_cmd_addr, last_cmd_len}, {30'h123, 6'd1});
    chk("t1_nbeats", log_data.size() - b, 1);
    if (log_data.size() > b)
      chk("t1_beat", {log_op[b], log_data[b], log_src[b], log_lo[b], log_err[b]},
          {3'd1, 8'hA5, 2'd2, 1'b1, 1'b0});

    // Get of size 2 with d_ready toggling. The command must be aligned.
    dr_mode = 1;
    ovr[0] = 8'h11; ovr[1] = 8'h22; ovr[2] = 8'h33; ovr[3] = 8'h44; ovr_n = 4;
    b = log_data.size();
    send(3'd4, 3'd2, 2'd1, 30'h1006);
    wait_idle(500, "t2_idle");
    chk("t2_cmd", {last_cmd_addr, last_cmd_len}, {30'h1004, 6'd4});
    chk("t2_nbeats", log_data.size() - b, 4);
    if (log_data.size() >= b + 4)
      chk("t2_bytes", {log_data[b], log_data[b+1], log_data[b+2], log_data[b+3],
                       log_lo[b], log_lo[b+1], log_lo[b+2], log_lo[b+3]},
          {8'h11, 8'h22, 8'h33, 8'h44, 4'b0101});
    ovr_n = 0;

    // PutFull of size 2: 4 beats drained, no command, then one error ack.
    dr_mode = 0;
    b = log_data.size();
    begin
      int c0;
      c0 = cmd_cnt;
      send(3'd0, 3'd2, 2'd1, 30'h305);
      wait_idle(500, "t3_idle");
      chk("t3_no_cmd", cmd_cnt - c0, 0);
    end
    chk("t3_nbeats", log_data.size() - b, 1);
    if (log_data.size() > b)
      chk("t3_ack", {log_op[b], log_err[b], log_size[b], log_src[b], log_lo[b], log_data[b]},
          {3'd0, 1'b1, 3'd2, 2'd1, 1'b1, 8'd0});

    // cmd_ready held low for 10 cycles while a second request waits.
    cr_mode = 1; dr_mode = 2;
    send(3'd4, 3'd3, 2'd0, 30'h2A5);
    fork
      send(3'd0, 3'd0, 2'd3, 30'h10);
      begin
        repeat (10) begin
          @(negedge clock);
          chk("t4_cmd_hold", {cmd_valid, a_ready, cmd_addr, cmd_len}, {1'b1, 1'b0, 30'h2A0, 6'd8});
        end
        cr_mode = 2;
      end
    join
    wait_idle(500, "t4_idle");
    cr_mode = 0;

    // A size above 5 is clamped to a 32-byte command.
    send(3'd4, 3'd6, 2'd2, 30'h3F);
    wait_idle(1000, "t_clamp_idle");
    chk("t_clamp_cmd", {last_cmd_addr, last_cmd_len}, {30'h20, 6'd32});

    // Reset during DATA after 2 of 8 beats, followed by a clean Get.
    dr_mode = 2;
    send(3'd4, 3'd3, 2'd1, 30'h40);
    begin
      bit hit;
      hit = 0;
      for (int t = 0; t < 500 && !hit; t++) begin
        @(posedge clock);
        #2;
        hit = m_data && (m_idx == 2);
      end
      if (!hit) fail_bound("t5_reach_beat2");
    end
    reset = 1;
    #1;
    chk("t5_rst_ctl", {a_ready, d_valid, cmd_valid, rx_ready}, 4'b1000);
    chk("t5_rst_d", {d_opcode, d_size, d_source, d_addr_lo, d_data, d_error, cmd_addr, cmd_len}, 0);
    @(posedge clock);
    #1;
    reset = 0;
    ovr[0] = 8'h3C; ovr_n = 1;
    b = log_data.size();
    send(3'd4, 3'd0, 2'd3, 30'h7);
    wait_idle(500, "t5_idle");
    chk("t5_after", log_data.size() - b, 1);
    if (log_data.size() > b)
      chk("t5_beat", {log_op[b], log_data[b], log_src[b], log_lo[b], log_err[b]},
          {3'd1, 8'h3C, 2'd3, 1'b1, 1'b0});
    ovr_n = 0;

`ifdef UX607_QSPI_RDBRIDGE_TIMEOUT_EN
    // One byte, then silence: the second beat must time out.
    dr_mode = 2; rx_limit = 1; ovr[0] = 8'h5A; ovr_n = 1;
    b = log_data.size();
    send(3'd4, 3'd1, 2'd0, 30'h10);
    wait_idle(1000, "t6_idle");
    chk("t6_nbeats", log_data.size() - b, 2);
    if (log_data.size() >= b + 2)
      chk("t6_beats", {log_data[b], log_err[b], log_data[b+1], log_err[b+1], log_op[b+1]},
          {8'h5A, 1'b0, 8'h00, 1'b1, 3'd1});
    rx_limit = 32; ovr_n = 0;
`endif

    // Random traffic, checked every cycle against the model.
    dr_mode = 0; cr_mode = 0;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      op = (sel < 5) ? 3'd4 : 3'($urandom_range(0, 7));
      send(op, 3'($urandom_range(0, 7)), 2'($urandom), 30'($urandom));
    end
    wait_idle(2000, "rand_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
